// File: rtl/factor_sequencer.sv
// rtl/factor_sequencer.sv - serial trial-division divisibility mask for divisors 2..19
// Optional FACTOR_SEQ_EARLY_EXIT_EN: skip divisors larger than the operand in one edge.
module factor_sequencer (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [7:0]  number,
    output logic        busy,
    output logic        done,
    output logic [17:0] factors,
    output logic [4:0]  factor_count
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_DIV  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]  state_q, state_d;
    logic [7:0]  n_q, n_d;
    logic [4:0]  d_q, d_d;
    logic [2:0]  bit_q, bit_d;
    logic [5:0]  rem_q, rem_d;
    logic [17:0] mask_q, mask_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [17:0] factors_q, factors_d;
    logic [4:0]  fcount_q, fcount_d;

    logic [5:0]  shifted;
    logic [5:0]  rem_next;
    logic        skip;

    // rem never exceeds 18, so its low five bits carry the whole value
    assign shifted  = {rem_q[4:0], n_q[bit_q]};
    assign rem_next = (shifted >= {1'b0, d_q}) ? (shifted - {1'b0, d_q}) : shifted;

`ifdef FACTOR_SEQ_EARLY_EXIT_EN
    assign skip = (bit_q == 3'd7) && (n_q != 8'd0) && ({3'b000, d_q} > n_q);
`else
    assign skip = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        n_d       = n_q;
        d_d       = d_q;
        bit_d     = bit_q;
        rem_d     = rem_q;
        mask_d    = mask_q;
        cnt_d     = cnt_q;
        factors_d = factors_q;
        fcount_d  = fcount_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    n_d     = number;
                    d_d     = 5'd2;
                    bit_d   = 3'd7;
                    rem_d   = 6'd0;
                    mask_d  = 18'd0;
                    cnt_d   = 5'd0;
                    state_d = S_DIV;
                end
            end
            S_DIV: begin
                if (skip || (bit_q == 3'd0)) begin
                    if (!skip && (rem_next == 6'd0)) begin
                        mask_d = mask_q | (18'd1 << (d_q - 5'd2));
                        cnt_d  = cnt_q + 5'd1;
                    end
                    if (d_q == 5'd19) begin
                        factors_d = mask_d;
                        fcount_d  = cnt_d;
                        state_d   = S_DONE;
                    end else begin
                        d_d   = d_q + 5'd1;
                        bit_d = 3'd7;
                        rem_d = 6'd0;
                    end
                end else begin
                    bit_d = bit_q - 3'd1;
                    rem_d = rem_next;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            n_q       <= 8'd0;
            d_q       <= 5'd0;
            bit_q     <= 3'd0;
            rem_q     <= 6'd0;
            mask_q    <= 18'd0;
            cnt_q     <= 5'd0;
            factors_q <= 18'd0;
            fcount_q  <= 5'd0;
        end else begin
            state_q   <= state_d;
            n_q       <= n_d;
            d_q       <= d_d;
            bit_q     <= bit_d;
            rem_q     <= rem_d;
            mask_q    <= mask_d;
            cnt_q     <= cnt_d;
            factors_q <= factors_d;
            fcount_q  <= fcount_d;
        end
    end

    assign busy         = (state_q == S_DIV);
    assign done         = (state_q == S_DONE);
    assign factors      = factors_q;
    assign factor_count = fcount_q;
endmodule

// File: tb/tb_factor_sequencer.sv
// tb/tb_factor_sequencer.sv - scoreboard bench for factor_sequencer
module tb_factor_sequencer;
    logic        clk;
    logic        rst_n;
    logic        start;
    logic [7:0]  number;
    logic        busy;
    logic        done;
    logic [17:0] factors;
    logic [4:0]  factor_count;

    typedef struct {
        logic [17:0] f;
        logic [4:0]  c;
        int          lat;
        int          num;
    } exp_t;

    exp_t exp_q[$];
    int checks   = 0;
    int failures = 0;
    int busy_cycles = 0;
    logic [17:0] held_f = 18'd0;

    factor_sequencer dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .number       (number),
        .busy         (busy),
        .done         (done),
        .factors      (factors),
        .factor_count (factor_count)
    );

    initial clk = 1'b0;
    always #50 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    // monitor: compares every done pulse against the head of the scoreboard
    always @(negedge clk) begin
        if (!rst_n) begin
            busy_cycles = 0;
            held_f = 18'd0;
        end else if (done) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_done factors=0x%0h", factors);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check($sformatf("factors_n%0d", e.num), 32'(factors), 32'(e.f));
                check($sformatf("count_n%0d", e.num), 32'(factor_count), 32'(e.c));
                check($sformatf("latency_n%0d", e.num), 32'(busy_cycles), 32'(e.lat));
                check($sformatf("busy_with_done_n%0d", e.num), 32'(busy), 32'd0);
            end
            busy_cycles = 0;
            held_f = factors;
        end else if (busy) begin
            busy_cycles++;
            if (factors !== held_f) check("factors_held", 32'(factors), 32'(held_f));
        end
    end

    task automatic issue(input logic [7:0] n);
        start  = 1'b1;
        number = n;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic expect_run(input logic [7:0] n, input logic [17:0] f, input logic [4:0] c,
                              input int lat_full, input int lat_early);
        exp_t e;
        e.f = f;
        e.c = c;
        e.num = int'(n);
`ifdef FACTOR_SEQ_EARLY_EXIT_EN
        e.lat = lat_early;
`else
        e.lat = lat_full;
`endif
        exp_q.push_back(e);
        issue(n);
    endtask

    task automatic wait_done();
        bit seen = 0;
        for (int i = 0; i < 400 && !seen; i++) begin
            @(negedge clk);
            if (done) seen = 1;
        end
        if (!seen) begin
            checks++;
            failures++;
            $display("FAIL done_timeout actual=0 required=1");
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n  = 1'b0;
        start  = 1'b0;
        number = 8'd0;
        repeat (3) @(negedge clk);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_factors", 32'(factors), 32'd0);
        check("reset_count", 32'(factor_count), 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;

        expect_run(8'd12,  18'h00417, 5'd5,  144, 95);  wait_done();
        expect_run(8'd255, 18'h0A00A, 5'd4,  144, 144); wait_done();
        expect_run(8'd19,  18'h20000, 5'd1,  144, 144); wait_done();
        expect_run(8'd1,   18'h00000, 5'd0,  144, 18);  wait_done();
        expect_run(8'd0,   18'h3FFFF, 5'd18, 144, 144); wait_done();

        // start while busy is dropped; operand change after capture is ignored
        expect_run(8'd12, 18'h00417, 5'd5, 144, 95);
        repeat (48) @(posedge clk);
        #1;
        issue(8'd7);
        wait_done();
        check("idle_after_done", 32'(busy), 32'd0);
        expect_run(8'd7, 18'h00020, 5'd1, 144, 60); wait_done();

        // asynchronous reset mid-computation publishes nothing
        expect_run(8'd255, 18'h0A00A, 5'd4, 144, 144); wait_done();
        issue(8'd12);
        repeat (39) @(posedge clk);
        #20;
        check("pre_reset_busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_factors", 32'(factors), 32'd0);
        check("abort_count", 32'(factor_count), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
        expect_run(8'd12, 18'h00417, 5'd5, 144, 95); wait_done();

        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/factor_sequencer.md
# factor_sequencer

Serial trial-division controller that produces the 18-bit divisibility mask for an 8-bit input: bit i set ⇔ (i+2) divides the number, for divisors 2..19. It replaces eighteen parallel divisibility checks with one shared 1-bit-per-cycle restoring remainder datapath, sequenced by an FSM behind a start/busy/done handshake. It sits between the input switches and the digit-cycling display logic of the top level.

## Interface
- No parameters; divisor range 2..19 and operand width 8 are fixed.
- clk  input  1  system clock (10 MHz on board)
- rst_n  input  1  asynchronous, active-low reset
- start  input  1  request a new factorization; sampled only in IDLE
- number  input  8  operand; captured on the accepting start edge
- busy  output  1  computation in progress
- done  output  1  one-cycle pulse: factors/factor_count just updated
- factors  output  18  bit i = (i+2) divides captured number; held until next done
- factor_count  output  5  population count of factors; updated with factors

## Operation
- Reset (rst_n low, asynchronous): FSM→IDLE, busy=0, done=0, factors=0, factor_count=0, internal registers cleared. Reset mid-computation aborts; no partial result is published.
- States: IDLE, DIV, DONE.
- IDLE: start=1 → capture number into n_q, divisor d=2, bit index=7, rem=0, running mask/count=0 → DIV. start=0 → stay.
- DIV, one edge per bit: rem' = {rem, n_q[bit]}; if rem' ≥ d then rem' −= d. rem is 6 bits (max shifted value 2·18+1=37).
- After bit 0: if rem'==0, set mask bit d−2 and increment count. Then d==19 → DONE (write factors, factor_count from running values); else d+=1, bit=7, rem=0, stay in DIV.
- DONE: done=1 for this cycle only, busy=0; → IDLE on next edge.
- busy=1 exactly while in DIV.
- start while busy or in DONE: ignored, not queued. number changes after capture: ignored.
- number=0: every divisor divides → factors=0x3FFFF, factor_count=18.
- number=1: factors=0, factor_count=0.

## Timing
- Start accepted at edge E0 → busy=1 from E0.
- Full mode: 8 edges per divisor × 18 divisors; last bit processed at E144 → DONE. done=1 and new factors visible in cycle after E144; busy=0 in that cycle. Back to IDLE at E145; earliest next start accepted at E145 (start sampled in IDLE).
- factors/factor_count change only on the edge that enters DONE.

## Configuration
- FACTOR_SEQ_EARLY_EXIT_EN defined: in DIV, when bit index==7 and n_q≠0 and d > n_q, record a non-factor and advance to next divisor (or DONE if d==19) in that single edge. Latency = 8·min(18, max(0, n_q−1)) + (number of skipped divisors), for n_q≠0; n_q=0 always 144. Results identical to full mode.
- Not defined: every divisor takes 8 edges; latency fixed at 144 edges.

## Test plan
- number=12, start pulse → after 144 edges (early exit: 95) done pulse; factors=0x00417, factor_count=5; busy low with done.
- number=255 → factors=0x0A00A (3,5,15,17), factor_count=4; latency 144 in both modes.
- number=19 → factors=0x20000, count=1; number=1 → factors=0, count=0, latency 18 with FACTOR_SEQ_EARLY_EXIT_EN, 144 without.
- number=0 → factors=0x3FFFF, count=18, latency 144 in both modes.
- start=12 accepted, then start with number=7 pulsed at E50 → ignored; result remains 12's mask; subsequent start in IDLE with 7 → factors=0x00020.
- Compute 255 to done, start 12, assert rst_n low at E40 → busy, done, factors, factor_count all 0 immediately (asynchronous); after release, start 12 completes normally with 0x00417.
